// File: rtl/halt_reporter_pkg.sv
// Shared types for the end-of-run reporter: report status codes,
// reporter FSM states and the drain counter width.
package sim_ctrl_pkg;

   localparam int unsigned STATUS_W = 2;
   localparam int unsigned DRAIN_W  = 4;

   typedef enum logic [STATUS_W-1:0] {
      ST_GOOD    = 2'd0,
      ST_BAD     = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_e;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_REPORT,
      S_DONE
   } state_e;

endpackage

// File: rtl/halt_reporter_if.sv
// Status-record handshake between the halt reporter and the host monitor.
interface halt_reporter_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned CYCLE_W = 64
);
   import sim_ctrl_pkg::*;

   logic                rpt_valid;
   logic                rpt_ready;
   logic [STATUS_W-1:0] rpt_status;
   logic [XLEN-1:0]     rpt_exit_code;
   logic [XLEN-1:0]     rpt_pc;
   logic [CYCLE_W-1:0]  rpt_cycles;
   logic [CYCLE_W-1:0]  rpt_instret;

   modport master (
      output rpt_valid, rpt_status, rpt_exit_code, rpt_pc, rpt_cycles, rpt_instret,
      input  rpt_ready
   );

   modport slave (
      input  rpt_valid, rpt_status, rpt_exit_code, rpt_pc, rpt_cycles, rpt_instret,
      output rpt_ready
   );

endinterface

// File: rtl/halt_reporter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   // Count on enable, hold once saturated.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/halt_reporter.sv
// End-of-run reporter: counts cycles/retires while running, stops on ebreak
// or watchdog expiry, freezes the core, then offers one status record.
module halt_reporter
   import sim_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     CYCLE_W      = 64,
   parameter longint unsigned TIMEOUT      = 64'd100000000,
   parameter int unsigned     DRAIN_CYCLES = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            wb_valid,
   input  logic            wb_ebreak,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [XLEN-1:0] a0,
   output logic            core_stall,
   output logic            halted,
   halt_reporter_if.master rpt
);

   localparam bit WDOG_EN = (TIMEOUT != 64'd0);
   localparam logic [CYCLE_W-1:0] TIMEOUT_LAST =
      CYCLE_W'(WDOG_EN ? (TIMEOUT - 64'd1) : 64'd0);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

   state_e               state;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic [CYCLE_W-1:0]   cycles_q;
   logic [CYCLE_W-1:0]   instret_q;
   logic                 in_run;
   logic                 ebreak_hit;
   logic                 timeout_hit;

   assign in_run      = (state == S_RUN);
   assign ebreak_hit  = in_run && wb_valid && wb_ebreak;
   assign timeout_hit = in_run && WDOG_EN && (cycles_q == TIMEOUT_LAST) && !ebreak_hit;

   // Counters only advance in RUN, so they freeze on the halting edge
   // with that cycle's increment already included.
   sat_counter #(.WIDTH(CYCLE_W)) u_cycles (
      .clock (clock),
      .reset (reset),
      .en    (in_run),
      .clr   (1'b0),
      .q     (cycles_q)
   );

   sat_counter #(.WIDTH(CYCLE_W)) u_instret (
      .clock (clock),
      .reset (reset),
      .en    (in_run && wb_valid),
      .clr   (1'b0),
      .q     (instret_q)
   );

   // Reporter FSM with capture registers and the drain down-counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= S_RUN;
         drain_cnt         <= '0;
         halted            <= 1'b0;
         core_stall        <= 1'b0;
         rpt.rpt_valid     <= 1'b0;
         rpt.rpt_status    <= '0;
         rpt.rpt_exit_code <= '0;
         rpt.rpt_pc        <= '0;
         rpt.rpt_cycles    <= '0;
         rpt.rpt_instret   <= '0;
      end else begin
         unique case (state)
            S_RUN: begin
               if (ebreak_hit) begin
                  rpt.rpt_status    <= (a0 == '0) ? ST_GOOD : ST_BAD;
                  rpt.rpt_exit_code <= a0;
                  rpt.rpt_pc        <= wb_pc;
                  drain_cnt         <= DRAIN_LOAD;
                  halted            <= 1'b1;
                  core_stall        <= 1'b1;
                  state             <= S_DRAIN;
               end else if (timeout_hit) begin
                  rpt.rpt_status    <= ST_TIMEOUT;
                  rpt.rpt_exit_code <= a0;
                  rpt.rpt_pc        <= '0;
                  drain_cnt         <= DRAIN_LOAD;
                  halted            <= 1'b1;
                  core_stall        <= 1'b1;
                  state             <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // A load of 0 or 1 both leave after a single DRAIN cycle.
               if (drain_cnt <= DRAIN_W'(1)) begin
                  rpt.rpt_cycles  <= cycles_q;
                  rpt.rpt_instret <= instret_q;
                  rpt.rpt_valid   <= 1'b1;
                  state           <= S_REPORT;
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
               end
            end
            S_REPORT: begin
               if (rpt.rpt_ready) begin
                  rpt.rpt_valid <= 1'b0;
                  state         <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_DONE;
            end
         endcase
      end
   end

endmodule
